// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed at issue into shadow registers and is committed to HI/LO after a fixed latency.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q, sh_hi_q, sh_lo_q;

  logic             a_neg, b_neg, neg_res;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0] res_hi_d, res_lo_d;

  // Signed ops work on magnitudes and fix the sign afterwards; op[0] marks the unsigned variants.
  // DIV overflow (most negative / -1) falls out naturally: quotient magnitude wraps back to a, remainder 0.
  always_comb begin
    a_neg    = a[WIDTH-1] & ~op[0];
    b_neg    = b[WIDTH-1] & ~op[0];
    neg_res  = a_neg ^ b_neg;
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    prod     = neg_res ? (~prod_mag + 1'b1) : prod_mag;
    q_mag    = '0;
    r_mag    = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    res_hi_d = '0;
    res_lo_d = '0;
    if (!op[1]) begin
      res_hi_d = prod[2*WIDTH-1:WIDTH];
      res_lo_d = prod[WIDTH-1:0];
    end else if (b == '0) begin
      res_hi_d = a;
      res_lo_d = '1;
    end else begin
      res_lo_d = neg_res ? (~q_mag + 1'b1) : q_mag;
      res_hi_d = a_neg   ? (~r_mag + 1'b1) : r_mag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            if (!op[2]) begin
              sh_hi_q <= res_hi_d;
              sh_lo_q <= res_lo_d;
              cnt_q   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (op == 3'd4) begin
              hi_q <= a;
            end else if (op == 3'd5) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cancel) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == CW'(1)) begin
            hi_q    <= sh_hi_q;
            lo_q    <= sh_lo_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_mdu_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit / native signed arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx, sy;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin p = longint'(sx) * longint'(sy); return p; end
      3'd1: return 64'(x) * 64'(y);
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expected result.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
        end else begin
          e = sb_q.pop_front();
          check("commit_hilo", {hi, lo}, e);
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit inject);
    logic [63:0] r;
    int n, lat;
    @(negedge clk);
    r = ref_result(o, x, y);
    if (!o[2]) sb_q.push_back(r);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!o[2]) begin
      lat = o[1] ? DC : MC;
      n = 0;
      while (busy && n < 200) begin
        n++;
        if (inject && n == 3) begin
          op = 3'd4; a = 32'd5; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      start = 1'b0;
      check("busy_cycles", 64'(n), 64'(lat));
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end else begin
      if (o == 3'd4) exp_hi = x;
      else if (o == 3'd5) exp_lo = x;
      check("mt_busy", 64'(busy), 64'd0);
    end
    check("hi", 64'(hi), 64'(exp_hi));
    check("lo", 64'(lo), 64'(exp_lo));
  endtask

  task automatic cancel_run(input int k);
    @(negedge clk);
    op = 3'd2; a = $urandom; b = $urandom | 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
    check("busy_before_cancel", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    repeat (DC + 2) @(negedge clk);
    check("cancel_idle", 64'(busy), 64'd0);
    check("cancel_hilo", {hi, lo}, {exp_hi, exp_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 reset = 1'b0;
    #10;
    check("reset_state", {30'h0, busy, done, hi}, 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);          // MULT -3*7
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);          // MULTU
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);          // DIV -7/2
    do_op(3'd3, 32'd7, 32'd0, 1'b0);                  // DIVU by zero
    do_op(3'd2, 32'h1234_5678, 32'd0, 1'b0);          // DIV by zero
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  // overflow, MTHI during busy
    do_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b0);          // MTHI
    do_op(3'd5, 32'hBEEF_0002, 32'd0, 1'b0);          // MTLO
    do_op(3'd6, 32'h1111_1111, 32'd3, 1'b0);          // no-op
    do_op(3'd7, 32'h2222_2222, 32'd3, 1'b0);          // no-op

    cancel_run(4);
    cancel_run(DC);

    // cancel alongside start in IDLE: nothing begins or is written
    @(negedge clk);
    op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    op = 3'd4; a = 32'd77;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", 64'(busy), 64'd0);
    repeat (MC + 2) @(negedge clk);
    check("cancel_start_hilo", {hi, lo}, {exp_hi, exp_lo});

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
    end

    // async reset in the middle of a multiply
    do_op(3'd4, 32'hAAAA_5555, 32'd0, 1'b0);
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_flags", {62'h0, busy, done}, 64'h0);
    check("midrun_reset_hilo", {hi, lo}, 64'h0);
    sb_q.delete();
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    do_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("final_busy", 64'(busy), 64'd0);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
